iir_bw_feedback_filter: RTL and testbench

Parametrised first-order comb-feedback IIR filter computing y[n] = a·x[n] + y[n−DELAY] on signed data. The product a·x is formed by an internal bit-serial Baugh-Wooley multiplier over COEF_W cycles. The coefficient is runtime-loadable, samples move under a valid/ready handshake, and the feedback delay is a parametrised circular buffer. It is the generalised successor to the fixed-coefficient, fixed 4-tap, free-running filter, and sits in the same sample datapath.

---
 rtl/iir_bw_feedback_filter.sv | 158 +++++++++++++++
 tb/tb_iir_bw_feedback_filter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_bw_feedback_filter.sv
// iir_bw_feedback_filter
//
// Comb-feedback IIR filter: y[n] = a*x[n] + y[n-DELAY] on signed data.
// The product a*x is built by a bit-serial Baugh-Wooley multiplier, one
// partial-product row per cycle over COEF_W cycles. The feedback path is a
// circular buffer of DELAY past outputs, indexed by accepted-sample count.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous, active-high reset (clears the delay line)
//   x_in     signed sample, DATA_W bits
//   coef     signed coefficient a, COEF_W bits, captured with x_in
//   x_valid  sample offered
//   x_ready  block can accept (high only while IDLE)
//   y_out    signed result, OUT_W bits, held between results
//   y_valid  one-cycle pulse marking a new y_out
//
// Handshake: a sample is taken at a rising edge where x_valid and x_ready
// are both high. An offer made while x_ready is low is not lost; it is
// taken at the first edge where the block is back in IDLE.
//
// Build option: define IIR_SAT_EN to saturate the OUT_W+1-bit feedback sum
// to the OUT_W range; when undefined the sum wraps (MSB dropped).

module iir_bw_feedback_filter #(
  parameter int DATA_W = 4,
  parameter int COEF_W = 4,
  parameter int OUT_W  = 8,
  parameter int DELAY  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] x_in,
  input  logic [COEF_W-1:0] coef,
  input  logic              x_valid,
  output logic              x_ready,
  output logic [OUT_W-1:0]  y_out,
  output logic              y_valid
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int CNT_W  = $clog2(COEF_W);
  localparam int PTR_W  = (DELAY > 1) ? $clog2(DELAY) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COEF_W - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DELAY - 1);

  // Baugh-Wooley correction constant: 2^(D-1) + 2^(C-1) + 2^(D+C-1).
  // Added (not OR-ed) because the first two coincide when D == C.
  localparam logic [PROD_W-1:0] ONE     = {{(PROD_W-1){1'b0}}, 1'b1};
  localparam logic [PROD_W-1:0] BW_CORR = (ONE << (DATA_W - 1))
                                        + (ONE << (COEF_W - 1))
                                        + (ONE << (PROD_W - 1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   x_q;
  logic [COEF_W-1:0]   coef_q;
  logic [CNT_W-1:0]    bit_cnt;
  logic [PROD_W-1:0]   prod;
  logic [PTR_W-1:0]    ptr;
  logic [OUT_W-1:0]    dly [DELAY];

  logic [DATA_W-1:0]   row;
  logic [PROD_W-1:0]   row_shifted;
  logic [OUT_W-1:0]    tap;
  logic [OUT_W:0]      sum;
  logic [OUT_W-1:0]    y_next;

  assign x_ready = (state == IDLE);

  // Partial-product row for the current coefficient bit. The x MSB term is
  // inverted on every row except the last; on the last row it is the only
  // term left uninverted. That is exactly "MSB xor last-row".
  always_comb begin
    row = '0;
    for (int j = 0; j < DATA_W; j++) begin
      row[j] = (x_q[j] & coef_q[bit_cnt])
             ^ ((j == DATA_W - 1) != (bit_cnt == CNT_LAST));
    end
    row_shifted = {{(PROD_W-DATA_W){1'b0}}, row} << bit_cnt;
  end

  // Feedback add at OUT_W+1 bits so overflow is visible before reduction.
  always_comb begin
    tap = dly[ptr];
    sum = {{(OUT_W+1-PROD_W){prod[PROD_W-1]}}, prod} + {tap[OUT_W-1], tap};
`ifdef IIR_SAT_EN
    if (sum[OUT_W] != sum[OUT_W-1]) begin
      y_next = sum[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                          : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      y_next = sum[OUT_W-1:0];
    end
`else
    y_next = sum[OUT_W-1:0];
`endif
  end

`ifndef IIR_SAT_EN
  logic unused_sum_msb;
  assign unused_sum_msb = sum[OUT_W];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      x_q     <= '0;
      coef_q  <= '0;
      bit_cnt <= '0;
      prod    <= '0;
      ptr     <= '0;
      y_out   <= '0;
      y_valid <= 1'b0;
      for (int k = 0; k < DELAY; k++) begin
        dly[k] <= '0;
      end
    end else begin
      y_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (x_valid) begin
            x_q     <= x_in;
            coef_q  <= coef;
            prod    <= BW_CORR;
            bit_cnt <= '0;
            state   <= MUL;
          end
        end
        MUL: begin
          prod <= prod + row_shifted;
          if (bit_cnt == CNT_LAST) begin
            bit_cnt <= '0;
            state   <= ACC;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ACC: begin
          // Tap is read combinationally above, so this write replaces
          // y[n-DELAY] with y[n] at the same slot.
          dly[ptr] <= y_next;
          ptr      <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
          y_out    <= y_next;
          y_valid  <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_bw_feedback_filter.sv
module tb_iir_bw_feedback_filter;

  localparam int DATA_W = 4;
  localparam int COEF_W = 4;
  localparam int OUT_W  = 8;
  localparam int DELAY  = 4;
  localparam int LAT    = COEF_W + 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] x_in;
  logic [COEF_W-1:0] coef;
  logic              x_valid;
  logic              x_ready;
  logic [OUT_W-1:0]  y_out;
  logic              y_valid;

  iir_bw_feedback_filter #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .DELAY(DELAY)
  ) dut (
    .clk(clk), .rst(rst), .x_in(x_in), .coef(coef),
    .x_valid(x_valid), .x_ready(x_ready), .y_out(y_out), .y_valid(y_valid)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int seen_valid = 0;
  int last_acc = -100;
  logic [OUT_W-1:0] last_y = '0;

  // scoreboard
  logic [OUT_W-1:0] exp_q[$];
  int               acc_q[$];

  // reference model of the delay line (independent of the RTL datapath)
  int mdly [DELAY];
  int mptr = 0;

  typedef struct {
    bit               rb;
    logic [DATA_W-1:0] x;
    logic [COEF_W-1:0] c;
    logic [OUT_W-1:0]  y;
  } vec_t;
  vec_t tbl[$];

  function automatic void add_vec(input bit rb, input int x, input int c, input int y);
    vec_t v;
    v.rb = rb;
    v.x  = DATA_W'(x);
    v.c  = COEF_W'(c);
    v.y  = OUT_W'(y);
    tbl.push_back(v);
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < DELAY; k++) mdly[k] = 0;
    mptr = 0;
  endfunction

  function automatic logic [OUT_W-1:0] model_step(input logic signed [DATA_W-1:0] x,
                                                  input logic signed [COEF_W-1:0] c);
    int s;
    logic [OUT_W-1:0] r;
    s = int'(x) * int'(c) + mdly[mptr];
`ifdef IIR_SAT_EN
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
`endif
    r = s[OUT_W-1:0];
    mdly[mptr] = int'($signed(r));
    mptr = (mptr + 1) % DELAY;
    return r;
  endfunction

  // output monitor, sampled 1 time unit after the falling edge
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      last_y = '0;
    end else if (y_valid) begin
      seen_valid++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_y_valid got y_out=%0d with empty queue", $signed(y_out));
      end else begin
        logic [OUT_W-1:0] e;
        int a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        checks++;
        if (y_out !== e) begin
          errors++;
          $display("FAIL y_out got %0d exp %0d", $signed(y_out), $signed(e));
        end
        checks++;
        if (cyc + 1 - a != LAT) begin
          errors++;
          $display("FAIL latency got %0d exp %0d", cyc + 1 - a, LAT);
        end
        checks++;
        if (x_ready !== 1'b1) begin
          errors++;
          $display("FAIL ready_with_valid got %b exp 1", x_ready);
        end
      end
      last_y = y_out;
    end else begin
      checks++;
      if (y_out !== last_y) begin
        errors++;
        $display("FAIL y_hold got %0d exp %0d", $signed(y_out), $signed(last_y));
      end
    end
  end

  // driver tasks
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    x_valid = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    model_clear();
    last_acc = -100;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    x_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [DATA_W-1:0] x, input logic [COEF_W-1:0] c,
                      input logic [OUT_W-1:0] y, input bit chk_gap);
    int budget;
    @(negedge clk);
    x_in = x;
    coef = c;
    x_valid = 1'b1;
    budget = 0;
    while (!x_ready && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (!x_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout got ready=%b exp 1", x_ready);
    end else begin
      exp_q.push_back(y);
      acc_q.push_back(cyc + 1);
      if (chk_gap && last_acc >= 0) begin
        checks++;
        if (cyc + 1 - last_acc != LAT) begin
          errors++;
          $display("FAIL accept_spacing got %0d exp %0d", cyc + 1 - last_acc, LAT);
        end
      end
      last_acc = cyc + 1;
      @(posedge clk);
    end
  endtask

  task automatic drain();
    int n;
    @(negedge clk);
    x_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sv;
    x_in = '0;
    coef = '0;
    x_valid = 1'b0;
    model_clear();

    // signed corners, taps empty
    add_vec(1, -8, -8,  64);
    add_vec(0, -8,  7, -56);
    add_vec(0,  7, -8, -56);
    add_vec(0, -1, -1,   1);
    // unit impulse train through the comb
    add_vec(1, 1, 7, 7);
    for (int i = 0; i < 7; i++) add_vec(0, 1, 7, (i < 3) ? 7 : 14);
    // overflow run
    for (int i = 0; i < 16; i++) begin
`ifdef IIR_SAT_EN
      add_vec(i == 0, 7, 7, (i < 4) ? 49 : (i < 8) ? 98 : 127);
`else
      add_vec(i == 0, 7, 7, (i < 4) ? 49 : (i < 8) ? 98 : (i < 12) ? -109 : -60);
`endif
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state held while idle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (y_out !== '0 || x_ready !== 1'b1 || y_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle got y=%0d rdy=%b vld=%b exp 0 1 0", y_out, x_ready, y_valid);
      end
    end

    // pass 0: x_valid held high, back-to-back; pass 1: 10 idle cycles between samples
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < tbl.size(); i++) begin
        if (tbl[i].rb) begin
          drain();
          do_reset(2);
        end
        send(tbl[i].x, tbl[i].c, tbl[i].y, pass == 0);
        if (pass == 1) idle(10);
      end
      drain();
    end

    // reset during MUL aborts the sample and clears the taps
    do_reset(2);
    @(negedge clk);
    x_in = 4'd3; coef = 4'd5; x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_acc = -100;
    sv = seen_valid;
    repeat (12) @(negedge clk);
    checks++;
    if (seen_valid != sv) begin
      errors++;
      $display("FAIL abort_no_valid got %0d exp 0", seen_valid - sv);
    end
    for (int i = 0; i < 5; i++) send(4'd3, 4'd5, (i < 4) ? 8'd15 : 8'd30, 1'b0);
    drain();

    // reset wins over a simultaneous offer
    @(negedge clk);
    rst = 1'b1; x_valid = 1'b1; x_in = 4'd5; coef = 4'd3;
    @(negedge clk);
    rst = 1'b0; x_valid = 1'b0;
    sv = seen_valid;
    checks++;
    if (x_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_vs_valid_ready got %b exp 1", x_ready);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (seen_valid != sv) begin
      errors++;
      $display("FAIL rst_vs_valid_output got %0d exp 0", seen_valid - sv);
    end

    // random samples with random gaps against the reference model
    do_reset(2);
    for (int i = 0; i < 40; i++) begin
      logic [DATA_W-1:0] rx;
      logic [COEF_W-1:0] rc;
      rx = DATA_W'($urandom_range(0, 15));
      rc = COEF_W'($urandom_range(0, 15));
      send(rx, rc, model_step(rx, rc), 1'b0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 4));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
